secure_regfile: RTL
===================

SECURE_REGFILE -- requirements
Module: secure_regfile

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each register and of the data buses, SHALL be >= 1.
REQ-002 Parameter DEPTH, default 8, number of registers, SHALL be >= 2; ADDR_W = clog2(DEPTH).
REQ-003 Parameter TID_WIDTH, default 4, width of the thread identifier.
REQ-004 Parameter OWNER_TID, default 0, the only thread id granted access.
REQ-005 Parameter VIOL_LIMIT, default 4, violation count that triggers lockdown, SHALL be >= 1.
REQ-006 Parameter CNT_W, default 8, violation counter width, SHALL satisfy 2^CNT_W - 1 >= VIOL_LIMIT.
REQ-007 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-008 Port rst, input, 1, asynchronous active-high reset.
REQ-009 Port req_valid, input, 1, request present this cycle; no backpressure, every request is accepted.
REQ-010 Port req_write, input, 1: 1 = write or lock, 0 = read.
REQ-011 Port req_lock, input, 1, with req_write=1 requests a lock of req_addr instead of a data write; ignored on reads.
REQ-012 Port req_addr, input, ADDR_W, register index.
REQ-013 Port req_wdata, input, DATA_WIDTH, write data.
REQ-014 Port req_tid, input, TID_WIDTH, requesting thread id.
REQ-015 Port rsp_valid, output, 1, response strobe.
REQ-016 Port rsp_rdata, output, DATA_WIDTH, read data.
REQ-017 Port rsp_err, output, 1, request was denied.
REQ-018 Port viol_count, output, CNT_W, saturating count of denied requests.
REQ-019 Port locked, output, DEPTH, per-register lock bits.
REQ-020 Port lockdown, output, 1, block is in LOCKDOWN state.

Function
REQ-021 Every accepted request SHALL produce exactly one response: rsp_valid=1 in the next cycle, registered; otherwise rsp_valid=0.
REQ-022 The block SHALL grant a request iff state = NORMAL, req_tid == OWNER_TID and req_addr < DEPTH.
REQ-023 A granted read SHALL return reg[req_addr] with rsp_err=0.
REQ-024 A granted write to an unlocked register SHALL update reg[req_addr] at the accepting edge with rsp_err=0.
REQ-025 A write to a locked register SHALL leave the register unchanged and respond rsp_err=1.
REQ-026 A granted lock SHALL set locked[req_addr] with rsp_err=0 and leave data unchanged; relocking an already locked register is not an error.
REQ-027 A lock bit SHALL be cleared only by reset.
REQ-028 Any denied request SHALL respond rsp_err=1 and rsp_rdata=0, and SHALL modify neither registers nor lock bits.
REQ-029 rsp_rdata SHALL be 0 whenever rsp_valid=0 or rsp_err=1.
REQ-030 viol_count SHALL increment by 1 for each response with rsp_err=1, saturating at 2^CNT_W - 1 without wrap.
REQ-031 FSM states SHALL be NORMAL and LOCKDOWN; NORMAL -> LOCKDOWN on the edge where viol_count reaches VIOL_LIMIT.
REQ-032 LOCKDOWN SHALL be left only through reset; in LOCKDOWN every request, including from OWNER_TID, is denied.
REQ-033 lockdown SHALL be 1 exactly while the state is LOCKDOWN.

Reset
REQ-034 While rst=1: all registers, locked, viol_count, rsp_valid, rsp_err and rsp_rdata SHALL be 0, the state SHALL be NORMAL and lockdown 0.
REQ-035 A request in flight when rst asserts SHALL be discarded with no response after reset deasserts.

Structure
REQ-036 Package secure_regfile_pkg SHALL hold the FSM state enum and the response-error encoding.
REQ-037 Sub-module secure_access_check SHALL hold the combinational grant/deny decision (tid, address range, lock, state).

Verification
REQ-038 Reset, then tid 0 writes 0xDEADBEEF to addr 3 and reads it back -> read response next cycle, rdata 0xDEADBEEF, err 0.
REQ-039 Tid 5 reads addr 3 -> rsp_err 1, rdata 0, viol_count 1; tid 5 writes 0x1 to addr 3 -> addr 3 still 0xDEADBEEF.
REQ-040 Tid 0 locks addr 2, then writes 0x55 to addr 2 -> lock err 0, locked[2]=1, write err 1, addr 2 still 0.
REQ-041 Four denied requests (VIOL_LIMIT=4) -> lockdown 1; a following tid 0 read of addr 3 -> err 1, rdata 0.
REQ-042 Back-to-back requests every cycle for 16 cycles -> 16 responses, each one cycle after its request.
REQ-043 Assert rst during LOCKDOWN with registers locked -> all outputs 0, locked 0, state NORMAL; tid 0 access then granted.

Source files
------------

// File: rtl/secure_regfile_pkg.sv
// Shared types for the secure register file: controller state and response-error encoding.
package secure_regfile_pkg;

  typedef enum logic {
    ST_NORMAL   = 1'b0,
    ST_LOCKDOWN = 1'b1
  } state_e;

  typedef enum logic {
    RSP_OK  = 1'b0,
    RSP_ERR = 1'b1
  } rsp_err_e;

endpackage

// File: rtl/secure_access_check.sv
// Combinational grant/deny decision for one request: thread id, address range, lock bit and state.
module secure_access_check
  import secure_regfile_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 3,
  parameter int TID_WIDTH = 4,
  parameter int OWNER_TID = 0
) (
  input  state_e              state,
  input  logic                req_valid,
  input  logic                req_write,
  input  logic                req_lock,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [TID_WIDTH-1:0] req_tid,
  input  logic [DEPTH-1:0]    locked,
  output logic                grant,
  output logic                do_read,
  output logic                do_write,
  output logic                do_lock,
  output rsp_err_e            err
);

  logic in_range;
  logic tgt_locked;

  always_comb begin
    in_range   = ({1'b0, req_addr} < (ADDR_W + 1)'(DEPTH));
    grant      = req_valid && (state == ST_NORMAL) &&
                 (req_tid == TID_WIDTH'(OWNER_TID)) && in_range;
    tgt_locked = in_range ? locked[req_addr] : 1'b0;
    do_read    = grant && !req_write;
    // Locking is idempotent, so a lock request ignores the current lock bit.
    do_lock    = grant && req_write && req_lock;
    do_write   = grant && req_write && !req_lock && !tgt_locked;
    err        = (req_valid && !(do_read || do_lock || do_write)) ? RSP_ERR : RSP_OK;
  end

endmodule

// File: rtl/secure_regfile.sv
// Register file restricted to one owner thread, with write-once lock bits and lockdown on repeated violations.
module secure_regfile
  import secure_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int TID_WIDTH  = 4,
  parameter int OWNER_TID  = 0,
  parameter int VIOL_LIMIT = 4,
  parameter int CNT_W      = 8,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic                  req_lock,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [TID_WIDTH-1:0]  req_tid,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [CNT_W-1:0]      viol_count,
  output logic [DEPTH-1:0]      locked,
  output logic                  lockdown
);

  state_e                state;
  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  grant;
  logic                  do_read;
  logic                  do_write;
  logic                  do_lock;
  rsp_err_e              err;
  logic [CNT_W-1:0]      viol_next;

  secure_access_check #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .TID_WIDTH(TID_WIDTH),
    .OWNER_TID(OWNER_TID)
  ) u_check (
    .state    (state),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_lock (req_lock),
    .req_addr (req_addr),
    .req_tid  (req_tid),
    .locked   (locked),
    .grant    (grant),
    .do_read  (do_read),
    .do_write (do_write),
    .do_lock  (do_lock),
    .err      (err)
  );

  always_comb begin
    viol_next = viol_count + 1'b1;
    lockdown  = (state == ST_LOCKDOWN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_NORMAL;
      locked     <= '0;
      viol_count <= '0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      rsp_valid <= req_valid;
      rsp_err   <= (err == RSP_ERR);
      rsp_rdata <= do_read ? regs[req_addr] : '0;

      if (do_write) begin
        regs[req_addr] <= req_wdata;
      end
      if (do_lock) begin
        locked[req_addr] <= 1'b1;
      end

      // Counter and lockdown advance on the same edge that registers the error response.
      if (err == RSP_ERR) begin
        if (viol_count != '1) begin
          viol_count <= viol_next;
        end
        if ((state == ST_NORMAL) && (viol_count != '1) &&
            (viol_next == CNT_W'(VIOL_LIMIT))) begin
          state <= ST_LOCKDOWN;
        end
      end
    end
  end

endmodule
